mcs4_clkgen: RTL and testbench

MCS4_CLKGEN -- requirements
Module: mcs4_clkgen

---
 rtl/mcs4_clkgen.sv | 126 ++++++++++++
 tb/tb_mcs4_clkgen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mcs4_clkgen.sv
// Two-phase non-overlapping clock, sync and power-on-clear generator for an MCS-4 system.
// Optional macro MCS4_SYNC_GEN_EN: generate sync_pad during X3 instead of tying it low.
`timescale 1ns/1ps

module mcs4_clkgen #(
  parameter int PHASE_LEN  = 4,
  parameter int POC_CYCLES = 16
) (
  input  logic       sysclk,
  input  logic       sysrst_n,
  input  logic       run,
  input  logic       poc_req,
  output logic       clk1_pad,
  output logic       clk2_pad,
  output logic       sync_pad,
  output logic       poc_pad,
  output logic [2:0] subcycle,
  output logic       cycle_start,
  output logic       running
);

  localparam logic [7:0] PH_MAX   = 8'(PHASE_LEN - 1);
  localparam logic [7:0] POC_INIT = 8'(POC_CYCLES);

  typedef enum logic {ST_HALT, ST_RUN} state_t;

  state_t     state_q, state_d;
  logic [7:0] phase_q, phase_d;
  logic [1:0] quarter_q, quarter_d;
  logic [2:0] sub_q, sub_d;
  logic       clk1_q, clk1_d;
  logic       clk2_q, clk2_d;
  logic       sync_q, sync_d;
  logic       cs_q, cs_d;
  logic       running_q, running_d;
  logic       poc_q, poc_d;
  logic [7:0] poc_cnt_q, poc_cnt_d;
  logic       last_phase;
  logic       mc_end;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    quarter_d  = quarter_q;
    sub_d      = sub_q;
    last_phase = (phase_q == PH_MAX);
    mc_end     = (state_q == ST_RUN) && last_phase && (quarter_q == 2'd3) && (sub_q == 3'd7);

    case (state_q)
      ST_HALT: begin
        phase_d   = 8'd0;
        quarter_d = 2'd0;
        sub_d     = 3'd0;
        if (run) state_d = ST_RUN;
      end
      default: begin
        if (last_phase) begin
          phase_d   = 8'd0;
          quarter_d = quarter_q + 2'd1;
          if (quarter_q == 2'd3) sub_d = sub_q + 3'd1;
        end else begin
          phase_d = phase_q + 8'd1;
        end
        // Halt only if run is still low at the very end of X3; a brief drop is ignored.
        if (mc_end && !run) state_d = ST_HALT;
      end
    endcase

    // Pad outputs are decoded from the next position so they leave the flops glitch-free.
    running_d = (state_d == ST_RUN);
    clk1_d    = running_d && (quarter_d == 2'd0);
    clk2_d    = running_d && (quarter_d == 2'd2);
    cs_d      = running_d && (phase_d == 8'd0) && (quarter_d == 2'd0) && (sub_d == 3'd0);
`ifdef MCS4_SYNC_GEN_EN
    sync_d    = running_d && (sub_d == 3'd7);
`else
    sync_d    = 1'b0;
`endif

    // A reload request wins over the end-of-cycle decrement.
    poc_d = poc_req || (poc_cnt_q != 8'd0);
    if (poc_req)
      poc_cnt_d = POC_INIT;
    else if (mc_end && (poc_cnt_q != 8'd0))
      poc_cnt_d = poc_cnt_q - 8'd1;
    else
      poc_cnt_d = poc_cnt_q;
  end

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      state_q   <= ST_HALT;
      phase_q   <= 8'd0;
      quarter_q <= 2'd0;
      sub_q     <= 3'd0;
      clk1_q    <= 1'b0;
      clk2_q    <= 1'b0;
      sync_q    <= 1'b0;
      cs_q      <= 1'b0;
      running_q <= 1'b0;
      poc_q     <= 1'b1;
      poc_cnt_q <= POC_INIT;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      quarter_q <= quarter_d;
      sub_q     <= sub_d;
      clk1_q    <= clk1_d;
      clk2_q    <= clk2_d;
      sync_q    <= sync_d;
      cs_q      <= cs_d;
      running_q <= running_d;
      poc_q     <= poc_d;
      poc_cnt_q <= poc_cnt_d;
    end
  end

  assign clk1_pad    = clk1_q;
  assign clk2_pad    = clk2_q;
  assign sync_pad    = sync_q;
  assign poc_pad     = poc_q;
  assign subcycle    = sub_q;
  assign cycle_start = cs_q;
  assign running     = running_q;

endmodule

// File: tb/tb_mcs4_clkgen.sv
// Bench for mcs4_clkgen: time-within-machine-cycle model compared every cycle, plus pinned literals.
`timescale 1ns/1ps

module tb_mcs4_clkgen;

  localparam int PL  = 2;
  localparam int POC = 3;
  localparam int MC  = 32 * PL;
`ifdef MCS4_SYNC_GEN_EN
  localparam logic [7:0] SYNC_X3 = 8'd1;
`else
  localparam logic [7:0] SYNC_X3 = 8'd0;
`endif

  logic       sysclk = 1'b0;
  logic       sysrst_n = 1'b0;
  logic       run = 1'b0;
  logic       poc_req = 1'b0;
  logic       clk1_pad, clk2_pad, sync_pad, poc_pad, cycle_start, running;
  logic [2:0] subcycle;

  mcs4_clkgen #(.PHASE_LEN(PL), .POC_CYCLES(POC)) u_dut (
    .sysclk(sysclk), .sysrst_n(sysrst_n), .run(run), .poc_req(poc_req),
    .clk1_pad(clk1_pad), .clk2_pad(clk2_pad), .sync_pad(sync_pad), .poc_pad(poc_pad),
    .subcycle(subcycle), .cycle_start(cycle_start), .running(running)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int failures = 0;
  int cur = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d sysclk=%0d t=%0t", name, act, exp, cur, $time);
    end
  endtask

  task automatic goto(input int k);
    while (cur < k) begin
      @(negedge sysclk);
      cur++;
    end
  endtask

  // Model: m_t is the sysclk index inside the current machine cycle (0..MC-1).
  bit m_run;
  int m_t;
  int m_cnt;
  bit m_poc;

  always @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      m_run <= 1'b0;
      m_t   <= 0;
      m_cnt <= POC;
      m_poc <= 1'b1;
    end else begin
      m_poc <= poc_req || (m_cnt != 0);
      if (poc_req) m_cnt <= POC;
      else if (m_run && m_t == MC - 1 && m_cnt > 0) m_cnt <= m_cnt - 1;
      if (!m_run) begin
        if (run) begin
          m_run <= 1'b1;
          m_t   <= 0;
        end
      end else if (m_t == MC - 1) begin
        m_t   <= 0;
        m_run <= run;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  always @(negedge sysclk) begin
    if (cmp_en) begin
      chk("m_clk1", {7'd0, clk1_pad}, {7'd0, m_run && ((m_t / PL) % 4 == 0)});
      chk("m_clk2", {7'd0, clk2_pad}, {7'd0, m_run && ((m_t / PL) % 4 == 2)});
      chk("m_cycle_start", {7'd0, cycle_start}, {7'd0, m_run && (m_t == 0)});
      chk("m_subcycle", {5'd0, subcycle}, m_run ? 8'(m_t / (4 * PL)) : 8'd0);
      chk("m_running", {7'd0, running}, {7'd0, m_run});
      chk("m_poc", {7'd0, poc_pad}, {7'd0, m_poc});
      chk("m_sync", {7'd0, sync_pad}, (m_run && m_t >= 28 * PL) ? SYNC_X3 : 8'd0);
      chk("m_overlap", {7'd0, clk1_pad & clk2_pad}, 8'd0);
    end
  end

  initial begin
    repeat (3) @(negedge sysclk);
    cmp_en = 1'b1;
    chk("rst_poc", {7'd0, poc_pad}, 8'd1);
    chk("rst_running", {7'd0, running}, 8'd0);
    chk("rst_clk1", {7'd0, clk1_pad}, 8'd0);
    chk("rst_cs", {7'd0, cycle_start}, 8'd0);
    chk("rst_sub", {5'd0, subcycle}, 8'd0);

    sysrst_n = 1'b1;
    repeat (3) @(negedge sysclk);
    chk("halt_after_rst", {7'd0, running}, 8'd0);
    chk("halt_clk1", {7'd0, clk1_pad}, 8'd0);

    run = 1'b1;
    @(negedge sysclk);
    cur = 0;
    chk("s0_clk1", {7'd0, clk1_pad}, 8'd1);
    chk("s0_cs", {7'd0, cycle_start}, 8'd1);
    chk("s0_running", {7'd0, running}, 8'd1);
    goto(1);   chk("s1_clk1", {7'd0, clk1_pad}, 8'd1);
               chk("s1_cs", {7'd0, cycle_start}, 8'd0);
    goto(2);   chk("s2_clk1", {7'd0, clk1_pad}, 8'd0);
               chk("s2_clk2", {7'd0, clk2_pad}, 8'd0);
    goto(4);   chk("s4_clk2", {7'd0, clk2_pad}, 8'd1);
    goto(5);   chk("s5_clk2", {7'd0, clk2_pad}, 8'd1);
    goto(6);   chk("s6_clk2", {7'd0, clk2_pad}, 8'd0);
    goto(8);   chk("s8_clk1", {7'd0, clk1_pad}, 8'd1);
               chk("s8_cs", {7'd0, cycle_start}, 8'd0);
    goto(55);  chk("s55_sub", {5'd0, subcycle}, 8'd6);
               chk("s55_sync", {7'd0, sync_pad}, 8'd0);
    goto(56);  chk("s56_sub", {5'd0, subcycle}, 8'd7);
               chk("s56_sync", {7'd0, sync_pad}, SYNC_X3);
    goto(63);  chk("s63_sync", {7'd0, sync_pad}, SYNC_X3);
    goto(64);  chk("s64_cs", {7'd0, cycle_start}, 8'd1);
               chk("s64_sync", {7'd0, sync_pad}, 8'd0);

    // Short run drop well before the boundary must not halt.
    goto(140); run = 1'b0;
    goto(150); run = 1'b1;
    goto(192); chk("s192_running", {7'd0, running}, 8'd1);
               chk("s192_cs", {7'd0, cycle_start}, 8'd1);
               chk("s192_poc", {7'd0, poc_pad}, 8'd1);
    goto(193); chk("s193_poc", {7'd0, poc_pad}, 8'd0);

    // Drop run in M1, halt after X3, restart 10 sysclks later.
    goto(282); chk("s282_sub", {5'd0, subcycle}, 8'd3);
               run = 1'b0;
    goto(319); chk("s319_running", {7'd0, running}, 8'd1);
               chk("s319_sub", {5'd0, subcycle}, 8'd7);
    goto(320); chk("s320_running", {7'd0, running}, 8'd0);
               chk("s320_clk1", {7'd0, clk1_pad}, 8'd0);
    goto(325); chk("s325_running", {7'd0, running}, 8'd0);
    goto(330); run = 1'b1;
    goto(331); chk("s331_clk1", {7'd0, clk1_pad}, 8'd1);
               chk("s331_cs", {7'd0, cycle_start}, 8'd1);
               chk("s331_running", {7'd0, running}, 8'd1);

    // POC restart request in X2 with the counter already at zero.
    goto(381); chk("s381_sub", {5'd0, subcycle}, 8'd6);
               chk("s381_poc", {7'd0, poc_pad}, 8'd0);
               poc_req = 1'b1;
    goto(382); poc_req = 1'b0;
               chk("s382_poc", {7'd0, poc_pad}, 8'd1);
               chk("s382_sub", {5'd0, subcycle}, 8'd6);
    goto(523); chk("s523_poc", {7'd0, poc_pad}, 8'd1);
    goto(524); chk("s524_poc", {7'd0, poc_pad}, 8'd0);

    // Asynchronous reset while clk2 is high.
    goto(591); chk("s591_clk2", {7'd0, clk2_pad}, 8'd1);
    #2 sysrst_n = 1'b0;
    #1;
    chk("arst_clk2", {7'd0, clk2_pad}, 8'd0);
    chk("arst_poc", {7'd0, poc_pad}, 8'd1);
    chk("arst_running", {7'd0, running}, 8'd0);
    chk("arst_clk1", {7'd0, clk1_pad}, 8'd0);
    repeat (3) @(negedge sysclk);
    sysrst_n = 1'b1;
    @(negedge sysclk);
    chk("rel_clk1", {7'd0, clk1_pad}, 8'd1);
    chk("rel_cs", {7'd0, cycle_start}, 8'd1);
    chk("rel_poc", {7'd0, poc_pad}, 8'd1);
    repeat (70) @(negedge sysclk);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
